// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants, segment table, FSM state type and elaboration helpers
// for the round-robin BCD display scanner.
package bcd_display_scanner_pkg;

   // Active-low gfe_dcba patterns for a dark digit and a centre dash.
   localparam logic [6:0] SEG_BLANK = 7'b111_1111;
   localparam logic [6:0] SEG_DASH  = 7'b011_1111;

   // Common-anode digit patterns, element d is the glyph for decimal d.
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'b001_0000,  // 9
      7'b000_0000,  // 8
      7'b111_1000,  // 7
      7'b000_0010,  // 6
      7'b001_0010,  // 5
      7'b001_1001,  // 4
      7'b011_0000,  // 3
      7'b010_0100,  // 2
      7'b111_1001,  // 1
      7'b100_0000   // 0
   };

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      STORE = 2'd3
   } state_e;

   // 10^n, evaluated at elaboration to derive the overflow threshold.
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_display_scanner_seg7_decode.sv
// One HEX digit: BCD nibble plus blank/dash controls to an active-low pattern.
// Blank wins over dash so a reset display stays dark regardless of ovf.
module seg7_decode
   import bcd_display_scanner_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   input  logic       dash,
   output logic [6:0] seg
);

   // Priority select: blank, then dash, then the decimal glyph.
   always_comb begin
      seg = SEG_BLANK;
      if (blank) begin
         seg = SEG_BLANK;
      end else if (dash) begin
         seg = SEG_DASH;
      end else if (digit <= 4'd9) begin
         seg = SEG_TABLE[digit];
      end
   end

endmodule

// File: rtl/bcd_display_scanner.sv
// Serial double-dabble converter shared round-robin across N_CH channels.
// Each channel takes W+3 cycles (IDLE, LOAD, W x SHIFT, STORE); results land
// in per-channel display registers that feed N_CH*D seven-segment decoders.
module bcd_display_scanner
   import bcd_display_scanner_pkg::*;
#(
   parameter int N_CH = 3,
   parameter int W    = 8,
   parameter int D    = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [N_CH*W-1:0]     values,
   input  logic                  hold,
   input  logic                  blank_lz,
   output logic [N_CH*D*7-1:0]   hex,
   output logic [N_CH-1:0]       ovf,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int          CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int          CNT_W   = (W > 1) ? $clog2(W) : 1;
   localparam logic [63:0] MAX_VAL = pow10(D) - 64'd1;

   state_e                 state_q, state_d;
   logic [CH_W-1:0]        ch_q, ch_d;
   logic [W-1:0]           sr_q, sr_d;
   logic [4*D-1:0]         bcd_q, bcd_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   cand_q, cand_d;
   logic [N_CH*D*4-1:0]    digit_q, digit_d;
   logic [N_CH*D-1:0]      blank_q, blank_d;
   logic [N_CH-1:0]        ovf_q, ovf_d;
   logic                   frame_done_q, frame_done_d;

   logic [W-1:0]           cur_val;
   logic [4*D-1:0]         bcd_adj;
   logic [D-1:0]           new_blank;
   logic [3:0]             nib;
   logic                   lz;

   // State register; reset blanks every digit and parks the scanner on ch0.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         ch_q         <= '0;
         sr_q         <= '0;
         bcd_q        <= '0;
         cnt_q        <= '0;
         cand_q       <= 1'b0;
         digit_q      <= '0;
         blank_q      <= '1;
         ovf_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         sr_q         <= sr_d;
         bcd_q        <= bcd_d;
         cnt_q        <= cnt_d;
         cand_q       <= cand_d;
         digit_q      <= digit_d;
         blank_q      <= blank_d;
         ovf_q        <= ovf_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Next-state logic: channel mux, add-3 correction, leading-zero mask, FSM.
   always_comb begin
      state_d      = state_q;
      ch_d         = ch_q;
      sr_d         = sr_q;
      bcd_d        = bcd_q;
      cnt_d        = cnt_q;
      cand_d       = cand_q;
      digit_d      = digit_q;
      blank_d      = blank_q;
      ovf_d        = ovf_q;
      frame_done_d = 1'b0;
      cur_val      = '0;
      bcd_adj      = '0;
      new_blank    = '0;
      nib          = '0;
      lz           = 1'b1;

      for (int k = 0; k < N_CH; k++) begin
         if (ch_q == CH_W'(k)) begin
            cur_val = values[k*W +: W];
         end
      end

      // Nibbles >= 5 get +3 so the following shift carries into the next digit.
      for (int i = 0; i < D; i++) begin
         nib = bcd_q[4*i +: 4];
         bcd_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
      end

      // Walk from the top digit down; a digit blanks only while everything
      // above it is also zero, and digit 0 always shows.
      for (int j = D - 1; j >= 0; j--) begin
         nib = bcd_q[4*j +: 4];
         lz  = lz & (nib == 4'd0);
         new_blank[j] = blank_lz & ~cand_q & lz & (j != 0);
      end

      unique case (state_q)
         IDLE: begin
            if (!hold) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            sr_d    = cur_val;
            bcd_d   = '0;
            cnt_d   = '0;
            cand_d  = (64'(cur_val) > MAX_VAL);
            state_d = SHIFT;
         end
         SHIFT: begin
            // Bits shifted out of the top nibble only matter on overflow,
            // and overflowed results are shown as dashes anyway.
            {bcd_d, sr_d} = {bcd_adj, sr_q} << 1;
            if (cnt_q == CNT_W'(W - 1)) begin
               state_d = STORE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STORE: begin
            for (int k = 0; k < N_CH; k++) begin
               if (ch_q == CH_W'(k)) begin
                  digit_d[k*D*4 +: 4*D] = bcd_q;
                  blank_d[k*D +: D]     = new_blank;
                  ovf_d[k]              = cand_q;
               end
            end
            frame_done_d = (ch_q == CH_W'(N_CH - 1));
            ch_d         = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy       = (state_q != IDLE);
   assign ovf        = ovf_q;
   assign frame_done = frame_done_q;

   // One decoder per displayed digit; the channel's ovf bit drives its dashes.
   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      for (genvar j = 0; j < D; j++) begin : g_dig
         seg7_decode u_dec (
            .digit (digit_q[(k*D+j)*4 +: 4]),
            .blank (blank_q[k*D+j]),
            .dash  (ovf_q[k]),
            .seg   (hex[(k*D+j)*7 +: 7])
         );
      end
   end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for the BCD display scanner: a default 3x8-bit/2-digit
// instance and a 1x32-bit/9-digit instance.
module tb_bcd_display_scanner;
   import bcd_display_scanner_pkg::*;

   int checks = 0;
   int errors = 0;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          reset, hold, blank_lz;
   logic [23:0]   values;
   logic [41:0]   hex;
   logic [2:0]    ovf;
   logic          busy, frame_done;

   logic          reset2, hold2, blank2;
   logic [31:0]   values2;
   logic [62:0]   hex2;
   logic [0:0]    ovf2;
   logic          busy2, frame_done2;

   bcd_display_scanner #(.N_CH(3), .W(8), .D(2)) dut (
      .clock      (clock),
      .reset      (reset),
      .values     (values),
      .hold       (hold),
      .blank_lz   (blank_lz),
      .hex        (hex),
      .ovf        (ovf),
      .busy       (busy),
      .frame_done (frame_done)
   );

   bcd_display_scanner #(.N_CH(1), .W(32), .D(9)) dut2 (
      .clock      (clock),
      .reset      (reset2),
      .values     (values2),
      .hold       (hold2),
      .blank_lz   (blank2),
      .hex        (hex2),
      .ovf        (ovf2),
      .busy       (busy2),
      .frame_done (frame_done2)
   );

   // ---------------- reference glyphs ----------------
   localparam logic [6:0] G_BLANK = 7'b111_1111;
   localparam logic [6:0] G_DASH  = 7'b011_1111;

   function automatic logic [6:0] glyph(input int d);
      case (d)
         0: return 7'b100_0000;
         1: return 7'b111_1001;
         2: return 7'b010_0100;
         3: return 7'b011_0000;
         4: return 7'b001_1001;
         5: return 7'b001_0010;
         6: return 7'b000_0010;
         7: return 7'b111_1000;
         8: return 7'b000_0000;
         9: return 7'b001_0000;
         default: return G_BLANK;
      endcase
   endfunction

   // Two-digit channel image without blanking.
   function automatic logic [13:0] two(input int v);
      return {glyph(v / 10), glyph(v % 10)};
   endfunction

   // ---------------- checker / drivers ----------------
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Waits (bounded) for a frame_done pulse; n = negedges elapsed.
   task automatic wait_fd(input int which, output int n);
      logic fd;
      n = 0;
      do begin
         @(negedge clock);
         n++;
         fd = (which == 1) ? frame_done2 : frame_done;
      end while (!fd && n < 300);
   endtask

   task automatic wait_shift_ch(input int c, output logic found);
      int n;
      n = 0;
      found = 1'b0;
      while (n < 200 && !found) begin
         @(negedge clock);
         n++;
         found = (dut.state_q == SHIFT) && (dut.ch_q == 2'(c));
      end
   endtask

   task automatic wait_idle(output logic found);
      int n;
      n = 0;
      found = 1'b0;
      while (n < 200 && !found) begin
         @(negedge clock);
         n++;
         found = (dut.state_q == IDLE);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          n;
      int          fd_seen;
      logic        found;
      logic [62:0] exp2;

      reset    = 1'b1;
      hold     = 1'b0;
      blank_lz = 1'b0;
      values   = {8'd5, 8'd42, 8'd99};
      reset2   = 1'b1;
      hold2    = 1'b0;
      blank2   = 1'b0;
      values2  = 32'd0;

      // Reset state.
      repeat (2) @(negedge clock);
      check_eq("rst_hex", 64'(hex), 64'({42{1'b1}}));
      check_eq("rst_ovf", 64'(ovf), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_fd", 64'(frame_done), 64'd0);
      check_eq("rst_state", 64'(dut.state_q), 64'(IDLE));
      check_eq("rst_ch", 64'(dut.ch_q), 64'd0);
      check_eq("rst_hex2", 64'(hex2), 64'({63{1'b1}}));
      check_eq("rst_busy2", 64'(busy2), 64'd0);

      // First frame: 99 / 42 / 05, frame time 33 cycles.
      reset = 1'b0;
      wait_fd(0, n);
      check_eq("frame1_len", 64'(n), 64'd33);
      check_eq("frame1_hex", 64'(hex), 64'({two(5), two(42), two(99)}));
      check_eq("frame1_ovf", 64'(ovf), 64'd0);
      @(negedge clock);
      check_eq("fd_one_cycle", 64'(frame_done), 64'd0);
      wait_fd(0, n);
      check_eq("frame2_len", 64'(n), 64'd32);

      // Overflow: 100 and 255 dash out ch0; 99 clears it.
      values = {8'd5, 8'd42, 8'd100};
      wait_fd(0, n);
      check_eq("ovf100_len", 64'(n), 64'd33);
      check_eq("ovf100_hex", 64'(hex), 64'({two(5), two(42), G_DASH, G_DASH}));
      check_eq("ovf100_ovf", 64'(ovf), 64'd1);
      values = {8'd5, 8'd42, 8'd255};
      wait_fd(0, n);
      check_eq("ovf255_hex", 64'(hex), 64'({two(5), two(42), G_DASH, G_DASH}));
      check_eq("ovf255_ovf", 64'(ovf), 64'd1);
      values = {8'd5, 8'd42, 8'd99};
      wait_fd(0, n);
      check_eq("max99_hex", 64'(hex), 64'({two(5), two(42), two(99)}));
      check_eq("max99_ovf", 64'(ovf), 64'd0);

      // Leading-zero blanking: 7 -> " 7", 0 -> " 0", 60 -> "60".
      blank_lz = 1'b1;
      values   = {8'd60, 8'd0, 8'd7};
      wait_fd(0, n);
      check_eq("blank_hex", 64'(hex),
               64'({glyph(6), glyph(0), G_BLANK, glyph(0), G_BLANK, glyph(7)}));
      check_eq("blank_ovf", 64'(ovf), 64'd0);

      // Hold asserted during ch1 SHIFT.
      blank_lz = 1'b0;
      values   = {8'd5, 8'd42, 8'd99};
      wait_fd(0, n);
      check_eq("pre_hold_hex", 64'(hex), 64'({two(5), two(42), two(99)}));
      wait_shift_ch(1, found);
      check_eq("hold_found_shift", 64'(found), 64'd1);
      hold   = 1'b1;
      values = {8'd1, 8'd2, 8'd3};
      check_eq("hold_busy_shift", 64'(busy), 64'd1);
      wait_idle(found);
      check_eq("hold_reach_idle", 64'(found), 64'd1);
      check_eq("hold_ch_after", 64'(dut.ch_q), 64'd2);
      fd_seen = 0;
      repeat (20) begin
         @(negedge clock);
         if (frame_done) fd_seen++;
      end
      check_eq("hold_busy", 64'(busy), 64'd0);
      check_eq("hold_state", 64'(dut.state_q), 64'(IDLE));
      check_eq("hold_fd_low", 64'(fd_seen), 64'd0);
      check_eq("hold_hex", 64'(hex), 64'({two(5), two(42), two(99)}));
      hold = 1'b0;
      wait_fd(0, n);
      check_eq("unhold_len", 64'(n), 64'd11);
      check_eq("unhold_hex", 64'(hex), 64'({two(1), two(42), two(99)}));
      wait_fd(0, n);
      check_eq("unhold2_hex", 64'(hex), 64'({two(1), two(2), two(3)}));

      // Reset pulse mid-SHIFT with ovf[0] set.
      values = {8'd5, 8'd42, 8'd200};
      wait_fd(0, n);
      check_eq("pre_rst_ovf", 64'(ovf), 64'd1);
      wait_shift_ch(1, found);
      check_eq("rst_found_shift", 64'(found), 64'd1);
      reset = 1'b1;
      @(negedge clock);
      reset  = 1'b0;
      values = {8'd5, 8'd42, 8'd99};
      check_eq("midrst_hex", 64'(hex), 64'({42{1'b1}}));
      check_eq("midrst_ovf", 64'(ovf), 64'd0);
      check_eq("midrst_ch", 64'(dut.ch_q), 64'd0);
      check_eq("midrst_state", 64'(dut.state_q), 64'(IDLE));
      wait_fd(0, n);
      check_eq("midrst_len", 64'(n), 64'd33);
      check_eq("midrst_frame_hex", 64'(hex), 64'({two(5), two(42), two(99)}));

      // Wide instance: 9 digits of 32-bit value.
      values2 = 32'd999_999_999;
      reset2  = 1'b0;
      wait_fd(1, n);
      check_eq("w32_len", 64'(n), 64'd35);
      exp2 = '0;
      for (int j = 0; j < 9; j++) exp2[j*7 +: 7] = glyph(9);
      check_eq("w32_nines_hex", 64'(hex2), 64'(exp2));
      check_eq("w32_nines_ovf", 64'(ovf2), 64'd0);
      values2 = 32'd1_000_000_000;
      wait_fd(1, n);
      check_eq("w32_ovf_len", 64'(n), 64'd35);
      for (int j = 0; j < 9; j++) exp2[j*7 +: 7] = G_DASH;
      check_eq("w32_ovf_hex", 64'(hex2), 64'(exp2));
      check_eq("w32_ovf_ovf", 64'(ovf2), 64'd1);

      // ---------------- report ----------------
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
